frame_sequencer: RTL and testbench

//  Frame-level scheduler for the denoise pipeline (8->24 converter -> line buffers/control FSM -> median filter).

---
 rtl/frame_sequencer_pkg.sv | 22 ++
 rtl/frame_sequencer_if.sv | 40 ++++
 rtl/frame_sequencer_raster_counter.sv | 57 +++++
 rtl/frame_sequencer.sv | 136 +++++++++++++
 tb/tb_frame_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : frame_sequencer_pkg                                         |
// | Brief  : Shared types and defaults for the denoise frame sequencer:  |
// |          sequencer state encoding and default frame geometry.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package frame_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_ACCEPT = 2'd1,
    SEQ_DRAIN  = 2'd2,
    SEQ_DONE   = 2'd3
  } seq_state_t;

  localparam int DEF_WIDTH         = 64;
  localparam int DEF_HEIGHT        = 64;
  localparam int DEF_DRAIN_TIMEOUT = 1024;

endpackage
`default_nettype wire

// File: rtl/frame_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : frame_sequencer_if                                          |
// | Brief  : Handshake and status bundle around the frame sequencer.     |
// |          master : environment (converter, control unit, filter, top) |
// |          slave  : frame_sequencer                                    |
// |   start/pix_valid/cu_ready/flt_valid/flt_ready  master -> slave      |
// |   pix_ready/cu_valid/in_row/in_col/out_count,                        |
// |   busy/frame_done/overrun/timeout               slave  -> master     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface frame_sequencer_if;
  logic        start;
  logic        pix_valid;
  logic        pix_ready;
  logic        cu_valid;
  logic        cu_ready;
  logic        flt_valid;
  logic        flt_ready;
  logic [15:0] in_row;
  logic [15:0] in_col;
  logic [31:0] out_count;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic        timeout;

  modport master (
    output start, pix_valid, cu_ready, flt_valid, flt_ready,
    input  pix_ready, cu_valid, in_row, in_col, out_count,
           busy, frame_done, overrun, timeout
  );

  modport slave (
    input  start, pix_valid, cu_ready, flt_valid, flt_ready,
    output pix_ready, cu_valid, in_row, in_col, out_count,
           busy, frame_done, overrun, timeout
  );
endinterface
`default_nettype wire

// File: rtl/frame_sequencer_raster_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : raster_counter                                              |
// | Brief  : Row/column raster position counter for one frame.           |
// |   clk, resetn : clock, async active-low reset                        |
// |   inc         : advance one pixel (held once the last pixel is hit)  |
// |   clr         : return to row 0, col 0 (wins over inc)               |
// |   row, col    : current position                                     |
// |   last        : position is the final pixel of the frame             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module raster_counter #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  input  wire logic        inc,
  input  wire logic        clr,
  output logic [15:0]      row,
  output logic [15:0]      col,
  output logic             last
);

  localparam logic [15:0] c_last_col = 16'(WIDTH - 1);
  localparam logic [15:0] c_last_row = 16'(HEIGHT - 1);

  logic [15:0] r_row;
  logic [15:0] r_col;
  logic        w_last;

  assign w_last = (r_row == c_last_row) && (r_col == c_last_col);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_row <= '0;
      r_col <= '0;
    end else if (clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (inc && !w_last) begin
      // The final position is held so the frame end stays visible
      if (r_col == c_last_col) begin
        r_col <= '0;
        r_row <= r_row + 16'd1;
      end else begin
        r_col <= r_col + 16'd1;
      end
    end
  end

  assign row  = r_row;
  assign col  = r_col;
  assign last = w_last;

endmodule
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : frame_sequencer                                             |
// | Brief  : Frame-level scheduler for the denoise pipeline. Gates the   |
// |          pixel stream into the control unit, tracks input raster     |
// |          position, counts filtered output pixels and signals frame   |
// |          completion, over-delivery and drain stalls.                 |
// |   clk    : rising-edge clock                                         |
// |   resetn : asynchronous active-low reset                             |
// |   bus    : frame_sequencer_if.slave (handshakes + status)            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int HEIGHT        = DEF_HEIGHT,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  frame_sequencer_if.slave  bus
);

  localparam logic [31:0] c_total   = 32'(WIDTH * HEIGHT);
  localparam logic [31:0] c_timeout = 32'(DRAIN_TIMEOUT);

  seq_state_t  r_state;
  seq_state_t  w_next;

  logic [31:0] r_out_count;
  logic [31:0] r_idle;
  logic        r_frame_done;
  logic        r_overrun;
  logic        r_timeout;

  logic        w_accept;
  logic        w_drain;
  logic        w_counting;
  logic        w_start_ok;
  logic        w_pix_ready;
  logic        w_in_beat;
  logic        w_out_beat;
  logic        w_full;
  logic        w_drain_full;
  logic        w_idle_exp;
  logic        w_last;
  logic [15:0] w_row;
  logic [15:0] w_col;

  assign w_accept    = (r_state == SEQ_ACCEPT);
  assign w_drain     = (r_state == SEQ_DRAIN);
  assign w_counting  = w_accept || w_drain;
  assign w_start_ok  = bus.start && ((r_state == SEQ_IDLE) || (r_state == SEQ_DONE));
  assign w_pix_ready = bus.cu_ready && w_accept;
  assign w_in_beat   = bus.pix_valid && w_pix_ready;
  assign w_out_beat  = bus.flt_valid && bus.flt_ready;
  assign w_full      = (r_out_count == c_total);
  // The filter may already have finished during ACCEPT, so DRAIN can exit
  // on an already-full count as well as on the completing beat.
  assign w_drain_full = w_full || (w_out_beat && (r_out_count == c_total - 32'd1));
  assign w_idle_exp   = !w_out_beat && ((r_idle + 32'd1) == c_timeout);

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_in_raster (
    .clk    (clk),
    .resetn (resetn),
    .inc    (w_in_beat),
    .clr    (w_start_ok),
    .row    (w_row),
    .col    (w_col),
    .last   (w_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= SEQ_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SEQ_IDLE:   if (w_start_ok) w_next = SEQ_ACCEPT;
      SEQ_ACCEPT: if (w_in_beat && w_last) w_next = SEQ_DRAIN;
      SEQ_DRAIN:  if (w_drain_full || w_idle_exp) w_next = SEQ_DONE;
      SEQ_DONE:   if (w_start_ok) w_next = SEQ_ACCEPT;
      default:    w_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_count  <= '0;
      r_idle       <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_frame_done <= (w_next == SEQ_DONE) && (r_state != SEQ_DONE);
      if (w_start_ok) begin
        // Restart wins over any same-cycle output beat
        r_out_count <= '0;
        r_idle      <= '0;
        r_overrun   <= 1'b0;
        r_timeout   <= 1'b0;
      end else begin
        if (w_counting && w_out_beat) begin
          if (w_full) r_overrun   <= 1'b1;
          else        r_out_count <= r_out_count + 32'd1;
        end
        if ((r_state == SEQ_DRAIN || r_state == SEQ_DONE) && bus.pix_valid)
          r_overrun <= 1'b1;
        if (w_drain) begin
          r_idle <= w_out_beat ? 32'd0 : r_idle + 32'd1;
          if (!w_drain_full && w_idle_exp) r_timeout <= 1'b1;
        end else begin
          r_idle <= '0;
        end
      end
    end
  end

  assign bus.pix_ready  = w_pix_ready;
  assign bus.cu_valid   = bus.pix_valid && w_accept;
  assign bus.in_row     = w_row;
  assign bus.in_col     = w_col;
  assign bus.out_count  = r_out_count;
  assign bus.busy       = w_counting;
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;
  assign bus.timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_frame_sequencer                                          |
// | Brief  : Self-checking bench for frame_sequencer on a 4x4 frame with |
// |          an 8-cycle drain timeout. Stimulus pushes expected input    |
// |          coordinates and frame-end status into queues; a monitor     |
// |          pops and compares on every accepted beat and frame_done.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_frame_sequencer;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
  } coord_t;

  typedef struct packed {
    logic [31:0] cnt;
    logic        ov;
    logic        to;
  } done_t;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  int   done_pulses;

  coord_t coord_q[$];
  done_t  done_q[$];

  frame_sequencer_if bus ();

  frame_sequencer #(
    .WIDTH         (4),
    .HEIGHT        (4),
    .DRAIN_TIMEOUT (8)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int n);
    for (int k = 0; k < n; k++) begin
      coord_t c;
      c.row = 16'(k / 4);
      c.col = 16'(k % 4);
      coord_q.push_back(c);
    end
  endtask

  task automatic push_done(input int cnt, input logic ov, input logic to);
    done_t d;
    d.cnt = 32'(cnt);
    d.ov  = ov;
    d.to  = to;
    done_q.push_back(d);
  endtask

  // Monitor: compares on every accepted input beat and every frame_done pulse
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.cu_valid && bus.pix_ready) begin
        if (coord_q.size() == 0) begin
          chk("unexpected_input_beat", 32'd1, 32'd0);
        end else begin
          coord_t e;
          e = coord_q.pop_front();
          chk("beat_row", 32'(bus.in_row), 32'(e.row));
          chk("beat_col", 32'(bus.in_col), 32'(e.col));
        end
      end
      if (bus.frame_done) begin
        done_pulses++;
        if (done_q.size() == 0) begin
          chk("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_out_count", bus.out_count, d.cnt);
          chk("done_overrun", 32'(bus.overrun), 32'(d.ov));
          chk("done_timeout", 32'(bus.timeout), 32'(d.to));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; done_pulses = 0;
    resetn = 1'b0;
    bus.start = 1'b0; bus.pix_valid = 1'b0; bus.cu_ready = 1'b0;
    bus.flt_valid = 1'b0; bus.flt_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_pix_ready", 32'(bus.pix_ready), 0);
    chk("rst_in_row", 32'(bus.in_row), 0);
    chk("rst_in_col", 32'(bus.in_col), 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_flags", {29'd0, bus.frame_done, bus.overrun, bus.timeout}, 0);
    resetn = 1'b1;
    tick();

    // 1: full-rate frame, 16 beats in 16 cycles
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("t1_busy", 32'(bus.busy), 1);
    push_frame(16); push_done(16, 1'b0, 1'b0);
    bus.pix_valid = 1'b1; bus.cu_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    bus.pix_valid = 1'b0;
    chk("t1_drain_pix_ready", 32'(bus.pix_ready), 0);
    chk("t1_drain_busy", 32'(bus.busy), 1);
    chk("t1_hold_row", 32'(bus.in_row), 3);
    chk("t1_hold_col", 32'(bus.in_col), 3);
    bus.flt_valid = 1'b1; bus.flt_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    bus.flt_valid = 1'b0;
    chk("t1_frame_done", 32'(bus.frame_done), 1);
    chk("t1_busy_done", 32'(bus.busy), 0);
    tick();
    chk("t1_frame_done_pulse", 32'(bus.frame_done), 0);

    // 2: cu_ready toggling, beats only when ready
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    push_frame(16); push_done(16, 1'b1, 1'b0);
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.cu_ready = (i % 2 == 0);
      tick();
      if (i == 7) begin
        chk("t2_row_after4", 32'(bus.in_row), 1);
        chk("t2_col_after4", 32'(bus.in_col), 0);
      end
    end
    bus.pix_valid = 1'b0; bus.cu_ready = 1'b1;
    chk("t2_in_drain", 32'(bus.busy), 1);

    // 3: extra pixel offered in DRAIN
    bus.pix_valid = 1'b1;
    #1;
    chk("t3_pix_ready", 32'(bus.pix_ready), 0);
    chk("t3_cu_valid", 32'(bus.cu_valid), 0);
    tick();
    bus.pix_valid = 1'b0;
    chk("t3_overrun", 32'(bus.overrun), 1);
    bus.flt_valid = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    bus.flt_valid = 1'b0;
    tick();
    chk("t3_overrun_sticky", 32'(bus.overrun), 1);

    // 4: drain timeout after 10 of 16 output beats
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("t4_overrun_cleared", 32'(bus.overrun), 0);
    push_frame(16); push_done(10, 1'b0, 1'b1);
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    bus.pix_valid = 1'b0;
    bus.flt_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.flt_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("t4_timeout_early", 32'(bus.timeout), 0);
    tick();
    chk("t4_timeout", 32'(bus.timeout), 1);
    chk("t4_done_entered", 32'(bus.busy), 0);

    // 5: reset mid-frame after 7 beats
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    push_frame(7);
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bus.pix_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(bus.busy), 0);
    chk("t5_rst_row", 32'(bus.in_row), 0);
    chk("t5_rst_col", 32'(bus.in_col), 0);
    chk("t5_rst_timeout", 32'(bus.timeout), 0);
    #3;
    resetn = 1'b1;
    tick();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("t5_restart_row", 32'(bus.in_row), 0);
    chk("t5_restart_col", 32'(bus.in_col), 0);

    // 5b/6: input and output overlap, ignored start mid-frame
    push_frame(16); push_done(16, 1'b0, 1'b0);
    bus.pix_valid = 1'b1; bus.flt_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.start = (i == 5);
      tick();
    end
    bus.start = 1'b0; bus.pix_valid = 1'b0; bus.flt_valid = 1'b0;
    chk("t6_drain_full_count", bus.out_count, 16);
    chk("t6_drain_busy", 32'(bus.busy), 1);
    tick();
    chk("t6_frame_done", 32'(bus.frame_done), 1);

    // 6: back-to-back frame, start in DONE with a same-cycle output beat
    bus.start = 1'b1; bus.flt_valid = 1'b1; tick(); bus.start = 1'b0;
    chk("t6_restart_count", bus.out_count, 0);
    push_frame(16); push_done(16, 1'b0, 1'b0);
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    bus.pix_valid = 1'b0; bus.flt_valid = 1'b0;
    tick();
    chk("t6b_frame_done", 32'(bus.frame_done), 1);
    tick();
    tick();

    chk("total_frame_done_pulses", 32'(done_pulses), 5);
    chk("coord_queue_empty", 32'(coord_q.size()), 0);
    chk("done_queue_empty", 32'(done_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
